pe_sequencer: RTL and testbench

Central controller for the PE column array. It drives the shared `mode`, `pe_we`, `read_addr`, `write_addr`, `init_val` and PE-select lines that every PE consumes. It sequences one init load, then repeated generations (collision pass followed by propagation pass), and interleaves VGA readout passes that scan every PE's memory through `pe_select`. It is the initiator for the PE memory interface, which the PEs answer.

---
 rtl/hpp_pkg.sv | 30 +++
 rtl/pe_sequencer_if.sv | 25 ++
 rtl/pe_pass_counter.sv | 48 ++++
 rtl/pe_sequencer.sv | 151 +++++++++++++++
 tb/tb_pe_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hpp_pkg.sv
// Shared definitions for the PE array: mode codes seen by every PE,
// sequencer state encoding and default pass lags.
package hpp_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;
  localparam int GEN_W  = 16;
  localparam int LAG_W  = 4;
  localparam int CNT_W  = 12;

  localparam int COLL_LAG_DEF = 1;
  localparam int PROP_LAG_DEF = 2;

  typedef enum logic [1:0] {
    MODE_INIT = 2'd0,
    MODE_VGA  = 2'd1,
    MODE_COLL = 2'd2,
    MODE_PROP = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READY = 3'd2,
    S_COLL  = 3'd3,
    S_PROP  = 3'd4,
    S_VGA   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/pe_sequencer_if.sv
// Shared PE control bus: the sequencer drives it, every PE listens.
interface pe_sequencer_if
  import hpp_pkg::*;
#(
  parameter int PE_IDX_W = 9
) ();
  mode_t               mode;
  logic                pe_we;
  logic [ADDR_W-1:0]   read_addr;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   init_val;
  logic [PE_IDX_W-1:0] pe_sel;
  logic                vga_valid;
  logic [ADDR_W-1:0]   vga_row;
  logic                vga_last;

  modport master (
    output mode, pe_we, read_addr, write_addr, init_val,
           pe_sel, vga_valid, vga_row, vga_last
  );
  modport slave (
    input  mode, pe_we, read_addr, write_addr, init_val,
           pe_sel, vga_valid, vga_row, vga_last
  );
endinterface

// File: rtl/pe_pass_counter.sv
// Lagged read/write address generator for one COLL or PROP pass.
// Outputs are the values for the *next* cycle; the caller registers them.
module pe_pass_counter
  import hpp_pkg::*;
#(
  parameter int NUM_WORDS = 240
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              start,
  input  logic [LAG_W-1:0]  lag,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic              we,
  output logic              done
);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(NUM_WORDS - 1);

  logic [CNT_W-1:0] cnt, idx, last_idx;
  logic [LAG_W-1:0] lag_q, lag_e;
  logic             active;

  // A new pass presents cycle 0 while the running pass presents cnt+1.
  always_comb begin
    lag_e      = start ? lag : lag_q;
    idx        = start ? '0 : cnt + 1'b1;
    last_idx   = TOP + CNT_W'(lag_e);
    read_addr  = (idx > TOP) ? ADDR_W'(TOP) : ADDR_W'(idx);
    we         = (idx >= CNT_W'(lag_e)) && (idx <= last_idx);
    write_addr = ADDR_W'(idx - CNT_W'(lag_e));
    done       = active && (cnt == TOP + CNT_W'(lag_q));
  end

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      cnt    <= '0;
      lag_q  <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      lag_q  <= lag;
      active <= 1'b1;
    end else if (active) begin
      if (done) active <= 1'b0;
      else      cnt    <= cnt + 1'b1;
    end

endmodule

// File: rtl/pe_sequencer.sv
// PE column array controller: init load, collision/propagation generations
// and interleaved VGA readout passes over the shared PE bus.
module pe_sequencer
  import hpp_pkg::*;
#(
  parameter int NUM_WORDS = 240,
  parameter int NUM_PE    = 320,
  parameter int PE_IDX_W  = 9,
  parameter int COLL_LAG  = COLL_LAG_DEF,
  parameter int PROP_LAG  = PROP_LAG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              vga_req,
  input  logic              init_valid,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_ready,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  pe_sequencer_if.master    pe
);
  localparam logic [ADDR_W-1:0]   LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PE_IDX_W-1:0] LAST_PE   = PE_IDX_W'(NUM_PE - 1);

  seq_state_t        state;
  logic              vga_pend;
  logic [ADDR_W-1:0] init_cnt;
  logic              hs;
  logic              pc_start, pc_we, pc_done;
  logic [LAG_W-1:0]  pc_lag;
  logic [ADDR_W-1:0] pc_rd, pc_wr;

  assign hs = init_valid && init_ready;

  // The single pass counter is chained COLL -> PROP on the done cycle.
  always_comb begin
    pc_start = 1'b0;
    pc_lag   = LAG_W'(COLL_LAG);
    if (state == S_READY && !start && !vga_pend && run) pc_start = 1'b1;
    if (state == S_COLL && pc_done) begin
      pc_start = 1'b1;
      pc_lag   = LAG_W'(PROP_LAG);
    end
  end

  pe_pass_counter #(.NUM_WORDS(NUM_WORDS)) u_pass (
    .gclk      (clk),
    .grst_n    (reset),
    .start     (pc_start),
    .lag       (pc_lag),
    .read_addr (pc_rd),
    .write_addr(pc_wr),
    .we        (pc_we),
    .done      (pc_done)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= S_IDLE;
      vga_pend      <= 1'b0;
      init_cnt      <= '0;
      init_ready    <= 1'b0;
      gen_count     <= '0;
      busy          <= 1'b0;
      pe.mode       <= MODE_VGA;
      pe.pe_we      <= 1'b0;
      pe.read_addr  <= '0;
      pe.write_addr <= '0;
      pe.init_val   <= '0;
      pe.pe_sel     <= '0;
      pe.vga_valid  <= 1'b0;
      pe.vga_row    <= '0;
      pe.vga_last   <= 1'b0;
    end else begin
      pe.pe_we <= 1'b0;
      if (vga_req) vga_pend <= 1'b1;
      case (state)
        S_IDLE, S_READY:
          if (start) begin
            state      <= S_INIT;
            busy       <= 1'b1;
            pe.mode    <= MODE_INIT;
            init_ready <= 1'b1;
            init_cnt   <= '0;
          end else if (state == S_READY && vga_pend) begin
            state        <= S_VGA;
            busy         <= 1'b1;
            pe.mode      <= MODE_VGA;
            pe.read_addr <= '0;
            vga_pend     <= vga_req;
          end else if (pc_start) begin
            state   <= S_COLL;
            busy    <= 1'b1;
            pe.mode <= MODE_COLL;
          end
        S_INIT:
          if (hs) begin
            pe.pe_we      <= 1'b1;
            pe.write_addr <= init_cnt;
            pe.init_val   <= init_data;
            init_cnt      <= init_cnt + 1'b1;
            if (init_cnt == LAST_WORD) begin
              init_ready <= 1'b0;
              state      <= S_READY;
              busy       <= 1'b0;
            end
          end
        S_COLL:
          if (pc_done) begin
            state   <= S_PROP;
            pe.mode <= MODE_PROP;
          end
        S_PROP:
          if (pc_done) begin
            state     <= S_READY;
            busy      <= 1'b0;
            gen_count <= gen_count + 1'b1;
          end
        S_VGA:
          // Per row: one address cycle, then NUM_PE data beats.
          if (!pe.vga_valid) begin
            pe.vga_valid <= 1'b1;
            pe.pe_sel    <= '0;
            pe.vga_row   <= pe.read_addr;
            pe.vga_last  <= (pe.read_addr == LAST_WORD) && (NUM_PE == 1);
          end else if (pe.pe_sel != LAST_PE) begin
            pe.pe_sel   <= pe.pe_sel + 1'b1;
            pe.vga_last <= (pe.read_addr == LAST_WORD) &&
                           (pe.pe_sel == PE_IDX_W'(NUM_PE - 2));
          end else begin
            pe.vga_valid <= 1'b0;
            pe.vga_last  <= 1'b0;
            if (pe.vga_last) begin
              state <= S_READY;
              busy  <= 1'b0;
            end else begin
              pe.read_addr <= pe.read_addr + 1'b1;
            end
          end
        default: state <= S_IDLE;
      endcase
      if (pc_start || ((state == S_COLL || state == S_PROP) && !pc_done)) begin
        pe.read_addr <= pc_rd;
        pe.pe_we     <= pc_we;
        if (pc_we) pe.write_addr <= pc_wr;
      end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: NUM_WORDS=4, NUM_PE=3, plus a PROP_LAG=3 copy.
module tb_pe_sequencer;
  import hpp_pkg::*;

  localparam int NW  = 4;
  localparam int NPE = 3;

  typedef struct { logic [1:0] mode; logic [9:0] addr; logic [9:0] data; } wexp_t;
  typedef struct { logic [9:0] row; logic [1:0] sel; logic last; } vexp_t;

  logic       clk, rst_n, start, run, vga_req, init_valid;
  logic [9:0] init_data;
  logic       ir1, ir3, b1, b3;
  logic [15:0] gc1, gc3;
  logic       sel3, mon_en;

  pe_sequencer_if #(.PE_IDX_W(2)) if1 ();
  pe_sequencer_if #(.PE_IDX_W(2)) if3 ();

  pe_sequencer #(.NUM_WORDS(NW), .NUM_PE(NPE), .PE_IDX_W(2), .COLL_LAG(1), .PROP_LAG(2)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .run(run), .vga_req(vga_req),
    .init_valid(init_valid), .init_data(init_data), .init_ready(ir1),
    .gen_count(gc1), .busy(b1), .pe(if1));

  pe_sequencer #(.NUM_WORDS(NW), .NUM_PE(NPE), .PE_IDX_W(2), .COLL_LAG(1), .PROP_LAG(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .start(start), .run(run), .vga_req(vga_req),
    .init_valid(init_valid), .init_data(init_data), .init_ready(ir3),
    .gen_count(gc3), .busy(b3), .pe(if3));

  logic [1:0]  m_mode, m_sel;
  logic        m_we, m_vv, m_last, m_ir, m_busy;
  logic [9:0]  m_rd, m_wa, m_iv, m_row;
  logic [15:0] m_gc;

  always_comb begin
    m_mode = sel3 ? if3.mode       : if1.mode;
    m_we   = sel3 ? if3.pe_we      : if1.pe_we;
    m_rd   = sel3 ? if3.read_addr  : if1.read_addr;
    m_wa   = sel3 ? if3.write_addr : if1.write_addr;
    m_iv   = sel3 ? if3.init_val   : if1.init_val;
    m_sel  = sel3 ? if3.pe_sel     : if1.pe_sel;
    m_vv   = sel3 ? if3.vga_valid  : if1.vga_valid;
    m_row  = sel3 ? if3.vga_row    : if1.vga_row;
    m_last = sel3 ? if3.vga_last   : if1.vga_last;
    m_ir   = sel3 ? ir3 : ir1;
    m_busy = sel3 ? b3  : b1;
    m_gc   = sel3 ? gc3 : gc1;
  end

  int n_chk = 0;
  int n_err = 0;
  wexp_t wq[$];
  vexp_t vq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Write and VGA beats are matched in order against the scoreboard.
  always @(negedge clk) begin : mon
    wexp_t we_e;
    vexp_t ve_e;
    if (mon_en) begin
      if (m_we) begin
        chk("wr_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          we_e = wq.pop_front();
          chk("wr_mode", m_mode, we_e.mode);
          chk("wr_addr", m_wa, we_e.addr);
          if (we_e.mode == MODE_INIT) chk("wr_data", m_iv, we_e.data);
        end
      end
      if (m_vv) begin
        chk("vga_expected", vq.size() != 0, 1);
        if (vq.size() != 0) begin
          ve_e = vq.pop_front();
          chk("vga_row", m_row, ve_e.row);
          chk("vga_sel", m_sel, ve_e.sel);
          chk("vga_last", m_last, ve_e.last);
        end
      end else begin
        chk("vga_last_idle", m_last, 0);
      end
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_mode"}, m_mode, 1);
    chk({tag, "_we"}, m_we, 0);
    chk({tag, "_rd"}, m_rd, 0);
    chk({tag, "_wa"}, m_wa, 0);
    chk({tag, "_iv"}, m_iv, 0);
    chk({tag, "_ir"}, m_ir, 0);
    chk({tag, "_sel"}, m_sel, 0);
    chk({tag, "_vv"}, m_vv, 0);
    chk({tag, "_row"}, m_row, 0);
    chk({tag, "_gc"}, m_gc, 0);
    chk({tag, "_busy"}, m_busy, 0);
  endtask

  task automatic push_pass(input logic [1:0] m);
    for (int a = 0; a < NW; a++) wq.push_back('{mode: m, addr: 10'(a), data: 10'd0});
  endtask

  task automatic do_init();
    logic [9:0] words [4];
    words = '{10'h3FF, 10'h001, 10'h020, 10'h155};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("init_mode", m_mode, MODE_INIT);
    chk("init_busy", m_busy, 1);
    for (int k = 0; k < NW; k++) begin
      if (k % 2 == 1) begin
        init_valid = 1'b0;
        @(negedge clk);
      end
      chk("init_ready", m_ir, 1);
      init_valid = 1'b1;
      init_data  = words[k];
      wq.push_back('{mode: MODE_INIT, addr: 10'(k), data: words[k]});
      @(negedge clk);
    end
    init_valid = 1'b0;
    chk("init_ready_drop", m_ir, 0);
    chk("init_to_ready", m_busy, 0);
  endtask

  task automatic check_pass(input logic [1:0] m, input int lag, input int drop_at,
                            input int start_at, input int vga_at, input string tag);
    for (int c = 0; c <= NW - 1 + lag; c++) begin
      @(negedge clk);
      chk({tag, "_mode"}, m_mode, m);
      chk({tag, "_rd"}, m_rd, (c < NW - 1) ? c : NW - 1);
      chk({tag, "_we"}, m_we, c >= lag);
      chk({tag, "_busy"}, m_busy, 1);
      if (c == drop_at) run = 1'b0;
      start   = (c == start_at);
      vga_req = (c == vga_at);
    end
    start   = 1'b0;
    vga_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; run = 1'b0; vga_req = 1'b0;
    init_valid = 1'b0; init_data = '0; sel3 = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_init();

    // generation 1: run dropped and start pulsed mid-PROP
    push_pass(MODE_COLL);
    push_pass(MODE_PROP);
    run = 1'b1;
    check_pass(MODE_COLL, 1, -1, -1, -1, "g1_coll");
    check_pass(MODE_PROP, 2, 1, 1, -1, "g1_prop");
    @(negedge clk);
    chk("g1_gen_count", m_gc, 1);
    chk("g1_ready", m_busy, 0);
    chk("g1_we_off", m_we, 0);
    repeat (3) @(negedge clk);
    chk("g1_stay_ready", m_busy, 0);
    chk("g1_mode_hold", m_mode, MODE_PROP);

    // generation 2 with a VGA request during COLL
    push_pass(MODE_COLL);
    push_pass(MODE_PROP);
    for (int r = 0; r < NW; r++)
      for (int s = 0; s < NPE; s++)
        vq.push_back('{row: 10'(r), sel: 2'(s), last: (r == NW - 1) && (s == NPE - 1)});
    run = 1'b1;
    check_pass(MODE_COLL, 1, -1, -1, 1, "g2_coll");
    check_pass(MODE_PROP, 2, 0, -1, -1, "g2_prop");
    @(negedge clk);
    chk("g2_gen_count", m_gc, 2);
    chk("g2_ready", m_busy, 0);
    for (int i = 0; i < NW * (NPE + 1); i++) begin
      @(negedge clk);
      chk("vga_mode", m_mode, MODE_VGA);
      chk("vga_we", m_we, 0);
      chk("vga_busy", m_busy, 1);
      chk("vga_rd", m_rd, i / (NPE + 1));
      chk("vga_valid", m_vv, (i % (NPE + 1)) != 0);
    end
    @(negedge clk);
    chk("vga_done", m_busy, 0);
    chk("vga_valid_off", m_vv, 0);
    chk("sb_wr_drain", wq.size(), 0);
    chk("sb_vga_drain", vq.size(), 0);

    // asynchronous reset during PROP cycle 3
    mon_en = 1'b0;
    run = 1'b1;
    repeat (NW + 1 + 4) @(negedge clk);
    chk("rst_pre_mode", m_mode, MODE_PROP);
    chk("rst_pre_rd", m_rd, 3);
    rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", m_busy, 0);
    chk("post_rst_gc", m_gc, 0);
    chk("post_rst_mode", m_mode, MODE_VGA);

    // PROP_LAG=3 instance
    sel3 = 1'b1;
    mon_en = 1'b1;
    do_init();
    push_pass(MODE_COLL);
    push_pass(MODE_PROP);
    run = 1'b1;
    check_pass(MODE_COLL, 1, -1, -1, -1, "l3_coll");
    check_pass(MODE_PROP, 3, 0, -1, -1, "l3_prop");
    @(negedge clk);
    chk("l3_gen_count", m_gc, 1);
    chk("l3_ready", m_busy, 0);
    chk("l3_sb_drain", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
